// File: rtl/tff_counter_sequencer.sv
// Up/down counter sequencer built on a bank of T flip-flops: the controller
// produces per-bit toggle enables that load, step, pause and abort the count.
module tff_counter_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] t_vec,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lim_r;
  logic             dir_r;
  logic [WIDTH-1:0] init;
  logic [WIDTH-1:0] term;

  // Increment toggles bit i when every lower bit is 1 (carry ripples through).
  function automatic logic [WIDTH-1:0] up_mask(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      m[i] = m[i-1] & c[i-1];
    end
    return m;
  endfunction

  // Decrement toggles bit i when every lower bit is 0 (borrow ripples through).
  function automatic logic [WIDTH-1:0] dn_mask(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] m;
    m[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      m[i] = m[i-1] & ~c[i-1];
    end
    return m;
  endfunction

  always_comb begin
    init  = dir ? '0 : limit;
    term  = dir_r ? lim_r : '0;
    t_vec = '0;
    case (state)
      IDLE: if (start && !stop) t_vec = count ^ init;
      RUN:  if (!stop && (count != term)) t_vec = dir_r ? up_mask(count) : dn_mask(count);
      default: t_vec = '0;
    endcase
  end

  assign busy = (state == RUN) || (state == HOLD);

  // T-FF bank and controller share one edge; the bank only ever moves via t_vec.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      lim_r <= '0;
      dir_r <= 1'b1;
      done  <= 1'b0;
    end else begin
      count <= count ^ t_vec;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            lim_r <= limit;
            dir_r <= dir;
            state <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            state <= HOLD;
          end else if (count == term) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        HOLD: begin
          if (stop)       state <= IDLE;
          else if (start) state <= RUN;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Scoreboard bench for tff_counter_sequencer: stimulus queues per-cycle
// expectations, a monitor samples just before each rising edge and compares.
module tb_tff_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       dir = 1'b1;
  logic [3:0] limit = 4'd0;
  logic [3:0] t_vec;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] cnt;
    logic [3:0] tv;
    logic       bsy;
    logic       dn;
    string      nm;
  } exp_t;

  exp_t sbq[$];

  tff_counter_sequencer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .stop  (stop),
    .dir   (dir),
    .limit (limit),
    .t_vec (t_vec),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs at the falling edge; queue what the DUT must show before the next rise.
  task automatic step(input logic r, input logic st, input logic sp, input logic d,
                      input logic [3:0] lim, input logic chk, input logic [3:0] ec,
                      input logic [3:0] et, input logic eb, input logic ed, input string nm);
    @(negedge clk);
    rst = r; start = st; stop = sp; dir = d; limit = lim;
    if (chk) sbq.push_back('{ec, et, eb, ed, nm});
  endtask

  task automatic run_up(input int lim, input int c0);
    logic [3:0] l4, k4;
    l4 = 4'(lim);
    step(0, 1, 0, 1, l4, 1, 4'(c0), 4'(c0), 0, 0, "up_load");
    for (int k = 0; k < lim; k++) begin
      k4 = 4'(k);
      step(0, 0, 0, 1, ~l4, 1, k4, k4 ^ (k4 + 4'd1), 1, 0, "up_step");
    end
    step(0, 0, 0, 1, ~l4, 1, l4, 4'd0, 1, 0, "up_term");
    step(0, 1, 0, 1, l4, 1, l4, 4'd0, 0, 1, "up_done");
    step(0, 0, 0, 1, l4, 1, l4, 4'd0, 0, 0, "up_idle");
  endtask

  task automatic run_down(input int lim, input int c0);
    logic [3:0] l4, k4;
    l4 = 4'(lim);
    step(0, 1, 0, 0, l4, 1, 4'(c0), 4'(c0) ^ l4, 0, 0, "dn_load");
    for (int k = lim; k >= 1; k--) begin
      k4 = 4'(k);
      step(0, 0, 0, 1, 4'd2, 1, k4, k4 ^ (k4 - 4'd1), 1, 0, "dn_step");
    end
    step(0, 0, 0, 0, l4, 1, 4'd0, 4'd0, 1, 0, "dn_term");
    step(0, 0, 0, 0, l4, 1, 4'd0, 4'd0, 0, 1, "dn_done");
    step(0, 0, 0, 0, l4, 1, 4'd0, 4'd0, 0, 0, "dn_idle");
  endtask

  // Monitor: scoreboard pop, T-FF update rule, and +/-1 toggle-mask shape.
  initial begin
    exp_t       e;
    logic [3:0] pred = 4'd0;
    logic [3:0] up1, dn1;
    logic       have_prev = 1'b0;
    logic       prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      #4;
      if (have_prev && !prev_rst) begin
        checks++;
        if (count !== pred) begin
          errors++;
          $display("FAIL edge_update: count=%h expected=%h", count, pred);
        end
      end
      if (busy === 1'b1 && t_vec !== 4'd0) begin
        up1 = count + 4'd1;
        dn1 = count - 4'd1;
        checks++;
        if (t_vec !== (count ^ up1) && t_vec !== (count ^ dn1)) begin
          errors++;
          $display("FAIL step_mask: t_vec=%b count=%h", t_vec, count);
        end
      end
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        checks++;
        if ({count, t_vec, busy, done} !== {e.cnt, e.tv, e.bsy, e.dn}) begin
          errors++;
          $display("FAIL %s: got count=%h t_vec=%b busy=%b done=%b, want count=%h t_vec=%b busy=%b done=%b",
                   e.nm, count, t_vec, busy, done, e.cnt, e.tv, e.bsy, e.dn);
        end
      end
      pred      = count ^ t_vec;
      prev_rst  = rst;
      have_prev = !$isunknown({count, t_vec});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with start asserted
    step(1, 1, 0, 1, 4'd7, 0, 4'd0, 4'd0, 0, 0, "rst0");
    step(1, 1, 0, 1, 4'd7, 1, 4'd0, 4'd0, 0, 0, "rst1");
    step(0, 0, 0, 1, 4'd0, 1, 4'd0, 4'd0, 0, 0, "post_rst");

    // Up run to 5 with limit wiggled mid-run, then preset count to 3
    run_up(5, 0);
    run_up(3, 5);

    // Down from 15 starting at count 3: load toggles 1100, 8->7 toggles 1111
    run_down(15, 3);

    // Pause at 4 for three cycles, resume to 9
    step(0, 1, 0, 1, 4'd9, 1, 4'd0, 4'd0, 0, 0, "p_load");
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 4'd9, 1, 4'(k), 4'(k) ^ 4'(k + 1), 1, 0, "p_step");
    step(0, 0, 1, 1, 4'd9, 1, 4'd4, 4'd0, 1, 0, "p_stop");
    step(0, 0, 0, 1, 4'd9, 1, 4'd4, 4'd0, 1, 0, "p_hold1");
    step(0, 0, 0, 1, 4'd9, 1, 4'd4, 4'd0, 1, 0, "p_hold2");
    step(0, 1, 0, 1, 4'd0, 1, 4'd4, 4'd0, 1, 0, "p_resume");
    for (int k = 4; k < 9; k++) step(0, 0, 0, 1, 4'd0, 1, 4'(k), 4'(k) ^ 4'(k + 1), 1, 0, "p_step2");
    step(0, 0, 0, 1, 4'd0, 1, 4'd9, 4'd0, 1, 0, "p_term");
    step(0, 0, 0, 1, 4'd0, 1, 4'd9, 4'd0, 0, 1, "p_done");
    step(0, 0, 0, 1, 4'd0, 1, 4'd9, 4'd0, 0, 0, "p_idle");

    // Abort: stop held two cycles from RUN -> HOLD -> IDLE, count retained at 3
    step(0, 1, 0, 1, 4'd12, 1, 4'd9, 4'd9, 0, 0, "a_load");
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1, 4'd12, 1, 4'(k), 4'(k) ^ 4'(k + 1), 1, 0, "a_step");
    step(0, 0, 1, 1, 4'd12, 1, 4'd3, 4'd0, 1, 0, "a_stop1");
    step(0, 0, 1, 1, 4'd12, 1, 4'd3, 4'd0, 1, 0, "a_stop2");
    step(0, 0, 0, 1, 4'd12, 1, 4'd3, 4'd0, 0, 0, "a_idle1");
    step(0, 0, 0, 1, 4'd12, 1, 4'd3, 4'd0, 0, 0, "a_idle2");

    // limit=0: zero steps, straight to done
    run_up(0, 3);

    // start and stop together in IDLE: nothing happens
    step(0, 1, 1, 0, 4'd8, 1, 4'd0, 4'd0, 0, 0, "ss_idle1");
    step(0, 0, 0, 1, 4'd8, 1, 4'd0, 4'd0, 0, 0, "ss_idle2");

    // Reset mid-run at count 6
    step(0, 1, 0, 1, 4'd10, 1, 4'd0, 4'd0, 0, 0, "r_load");
    for (int k = 0; k < 6; k++) step(0, 0, 0, 1, 4'd10, 1, 4'(k), 4'(k) ^ 4'(k + 1), 1, 0, "r_step");
    step(1, 0, 0, 1, 4'd10, 1, 4'd6, 4'd1, 1, 0, "r_assert");
    step(0, 0, 0, 1, 4'd10, 1, 4'd0, 4'd0, 0, 0, "r_after1");
    step(0, 0, 0, 1, 4'd10, 1, 4'd0, 4'd0, 0, 0, "r_after2");

    repeat (2) @(negedge clk);
    #5;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
